// File: rtl/leaf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_pkg
//  Brief    : Shared FSM state encoding and default key increment for leaf_mu.
//  Revision : 1.0 - initial release
// ============================================================================
package leaf_pkg;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        RUN  = 1'b1
    } leaf_state_e;

    localparam logic [31:0] c_key_step_default = 32'h9E37_79B9;

endpackage
`default_nettype wire

// File: rtl/leaf_mu_if.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_mu_if
//  Brief    : Upstream/downstream handshake bundle for the leaf_mu decoder.
//  Revision : 1.0 - initial release
// ============================================================================
interface leaf_mu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             resync;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             locked;

    modport master (
        output in_valid, in_data, resync, out_ready,
        input  in_ready, out_valid, out_data, locked
    );

    modport slave (
        input  in_valid, in_data, resync, out_ready,
        output in_ready, out_valid, out_data, locked
    );
endinterface
`default_nettype wire

// File: rtl/leaf_skid.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_skid
//  Brief    : Two-entry registered output buffer with valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module leaf_skid #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             in_valid,
    output logic                  in_ready,
    input  wire logic [WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  wire logic             out_ready,
    output logic [WIDTH-1:0]      out_data
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // A full buffer still accepts when the head leaves on the same edge.
    assign in_ready  = rst_n & ((r_count != 2'd2) | out_ready);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule
`default_nettype wire

// File: rtl/leaf_mu.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_mu
//  Brief    : Seeded rolling-key XOR decoder with resync and skid output.
//  Revision : 1.0 - initial release
// ============================================================================
module leaf_mu
    import leaf_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] KEY_STEP = WIDTH'(c_key_step_default)
) (
    input  wire logic clk,
    input  wire logic rst_n,
    leaf_mu_if.slave  bus
);
    leaf_state_e      r_state;
    logic [WIDTH-1:0] r_key;
    logic             r_locked;
    logic             w_accept;
    logic             w_emit;

    assign w_accept   = bus.in_valid & bus.in_ready;
    // Resync discards the beat even when the FSM is already running.
    assign w_emit     = w_accept & (r_state == RUN) & ~bus.resync;
    assign bus.locked = r_locked;

    leaf_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_emit),
        .in_ready  (bus.in_ready),
        .in_data   (bus.in_data ^ r_key),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SYNC;
            r_key    <= '0;
            r_locked <= 1'b0;
        end else if (bus.resync) begin
            r_state  <= SYNC;
            r_locked <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                SYNC: begin
                    r_key    <= bus.in_data;
                    r_state  <= RUN;
                    r_locked <= 1'b1;
                end
                RUN: begin
                    r_key <= r_key + KEY_STEP;
                end
                default: begin
                    r_state  <= SYNC;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/leaf_mu.md
LEAF_MU -- requirements
Module: leaf_mu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of in_data, out_data and the key register.
REQ-002 Parameter KEY_STEP, default 32'h9E3779B9 truncated to WIDTH, SHALL set the per-beat key increment.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port in_valid, input, 1 bit: an upstream beat is present.
REQ-006 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 Port in_data, input, WIDTH bits: the encoded upstream beat.
REQ-008 Port resync, input, 1 bit: a single-cycle request to return to SYNC.
REQ-009 Port out_valid, output, 1 bit: a decoded beat is present.
REQ-010 Port out_ready, input, 1 bit: downstream accepts the beat.
REQ-011 Port out_data, output, WIDTH bits: the decoded beat.
REQ-012 Port locked, output, 1 bit: high when state is RUN.

Function
REQ-013 A beat SHALL be accepted on the input side when in_valid and in_ready are both high; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 FSM states SHALL be SYNC and RUN; reset state SHALL be SYNC.
REQ-015 In SYNC, the first accepted beat SHALL be the seed: key <= in_data, state <= RUN, and nothing is emitted.
REQ-016 In RUN, each accepted beat SHALL emit in_data ^ key, and key SHALL update to (key + KEY_STEP) mod 2^WIDTH on the same edge.
REQ-017 The emitted beat SHALL reach out_data with out_valid high on the cycle after acceptance (latency 1), with no combinational path from in_data to out_data.
REQ-018 Output buffering SHALL hold 2 entries (skid); in_ready SHALL be high when fewer than 2 entries are held, or when 2 are held and out_ready is high. Sustained throughput SHALL be 1 beat per cycle under continuous out_ready.
REQ-019 While out_valid is high and out_ready is low, out_data SHALL stay stable; beats SHALL NOT be dropped, duplicated or reordered.
REQ-020 When resync is high, state SHALL go to SYNC on the next edge and any beat accepted in that cycle SHALL be discarded as data. Buffered output entries SHALL still drain. Key SHALL be unchanged until the next seed.
REQ-021 When resync and a seed acceptance occur in the same cycle, resync SHALL win: the beat is discarded and state stays SYNC.
REQ-022 Key arithmetic SHALL wrap modulo 2^WIDTH with no saturation and no flag.
REQ-023 locked SHALL be registered state (RUN), not decoded from inputs.

Reset
REQ-024 Asserting rst_n low SHALL immediately force state=SYNC, key=0, buffer empty, out_valid=0, out_data=0, locked=0, in_ready=0.
REQ-025 In the first cycle after rst_n deasserts, in_ready SHALL be 1.
REQ-026 Reset mid-stream SHALL discard all buffered beats; the next accepted beat SHALL be treated as a seed.

Structure
REQ-027 The state enum (SYNC, RUN) and the KEY_STEP default constant SHALL live in the shared package leaf_pkg.
REQ-028 The 2-entry output buffer SHALL be a separate parameterised sub-module, leaf_skid, with a valid/ready interface on both sides; FSM and key logic stay in leaf_mu.

Verification (WIDTH=32, KEY_STEP default)
REQ-029 Seed 32'h10, then beat 32'h05 -> out_data 32'h15 one cycle after acceptance; locked=1 after the seed.
REQ-030 Continue with beat 32'h9E3779C9 -> out_data 32'h0; key becomes 32'h3C6EF382.
REQ-031 Seed 32'hFFFF_FFF0 with KEY_STEP=32'h20, then beats 0,0 -> out 32'hFFFF_FFF0, 32'h0000_0010 (wrap).
REQ-032 Hold out_ready=0 with in_valid=1 in RUN -> two beats buffered, then in_ready=0 and out_data stable. Release out_ready -> both beats emerge in order at 1 per cycle.
REQ-033 Pulse resync in the same cycle as an accepted beat -> no output for that beat, locked=0; the next beat is the seed.
REQ-034 Assert rst_n low with 2 beats buffered -> out_valid=0 immediately, no stale beat after release, and the first beat after release is treated as a seed.
